// File: rtl/rrf_tag_alloc.sv
// rrf_tag_alloc: rename-register (RRF) tag allocator.
// Circular buffer of RRF tags with wrap-bit head/tail pointers.
//  - Dispatch: hands out up to two consecutive tags per cycle (dpaddr1/2, dpen1/2),
//    stalls (stall_dp) when the registered free count cannot cover the request.
//  - Commit: retires up to two tags in program order (com1tag/com2tag, com1en/com2en).
//  - Mispredict: prmiss restores the allocation pointer from rollback_ptr.
// Ports:
//  clk, reset (sync, active-high)
//  req1, req2            dispatch requests
//  stall_dp              combinational stall
//  dpaddr1/2, dpen1/2    combinational allocation tags/enables
//  rrfptr                registered allocation pointer {wrap, tag}
//  com1tag/com2tag       oldest/second-oldest allocated tags
//  com1en, com2en        commit enables
//  prmiss, rollback_ptr  rollback request and snapshot
//  freenum               registered free-tag count
//  occ_hwm, stall_cnt    statistics outputs
// Optional feature macro: RRF_ALLOC_STATS_EN builds the occupancy high-water mark
// and stall counter; otherwise both outputs are tied to zero.
module rrf_tag_alloc #(
  parameter int unsigned RRF_NUM = 64,
  parameter int unsigned RRF_SEL = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req1,
  input  logic               req2,
  output logic               stall_dp,
  output logic [RRF_SEL-1:0] dpaddr1,
  output logic [RRF_SEL-1:0] dpaddr2,
  output logic               dpen1,
  output logic               dpen2,
  output logic [RRF_SEL:0]   rrfptr,
  output logic [RRF_SEL-1:0] com1tag,
  output logic [RRF_SEL-1:0] com2tag,
  input  logic               com1en,
  input  logic               com2en,
  input  logic               prmiss,
  input  logic [RRF_SEL:0]   rollback_ptr,
  output logic [RRF_SEL:0]   freenum,
  output logic [RRF_SEL:0]   occ_hwm,
  output logic [31:0]        stall_cnt
);

  localparam int unsigned PW = RRF_SEL + 1;
  localparam logic [PW-1:0] NUM = PW'(RRF_NUM);

  // Pointer and free-count state
  logic [PW-1:0] alloc_q, alloc_d;
  logic [PW-1:0] com_q, com_d;
  logic [PW-1:0] free_q, free_d;

  // Per-cycle decode
  logic [1:0]    nreq;
  logic [1:0]    ncom_raw;
  logic [1:0]    nalloc;
  logic [PW-1:0] ncom;
  logic [PW-1:0] occ_q;

  // Request/commit decode, stall and clipped commit count
  always_comb begin
    nreq     = 2'd0;
    ncom_raw = 2'd0;
    if (req1) begin
      nreq = 2'd1 + {1'b0, req2};
    end
    if (com1en) begin
      ncom_raw = 2'd1 + {1'b0, com2en};
    end
    occ_q    = NUM - free_q;
    // Free count is the start-of-cycle value; same-cycle commits are not visible.
    stall_dp = ~prmiss & (PW'(nreq) > free_q);
    // All-or-nothing: a two-tag request never gets a single tag.
    dpen1    = req1 & ~stall_dp & ~prmiss;
    dpen2    = dpen1 & req2;
    nalloc   = {1'b0, dpen1} + {1'b0, dpen2};
    // Commits beyond the current occupancy are dropped.
    ncom     = (PW'(ncom_raw) > occ_q) ? occ_q : PW'(ncom_raw);
  end

  // Next-state pointers and free count
  always_comb begin
    com_d   = com_q + ncom;
    alloc_d = alloc_q + PW'(nalloc);
    free_d  = free_q + ncom - PW'(nalloc);
    if (prmiss) begin
      // Occupancy after rollback is the modular distance from the post-commit head.
      alloc_d = rollback_ptr;
      free_d  = NUM - (rollback_ptr - com_d);
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_q <= '0;
      com_q   <= '0;
      free_q  <= NUM;
    end else begin
      alloc_q <= alloc_d;
      com_q   <= com_d;
      free_q  <= free_d;
    end
  end

  // Tag and pointer outputs
  always_comb begin
    dpaddr1 = alloc_q[RRF_SEL-1:0];
    dpaddr2 = alloc_q[RRF_SEL-1:0] + RRF_SEL'(1);
    com1tag = com_q[RRF_SEL-1:0];
    com2tag = com_q[RRF_SEL-1:0] + RRF_SEL'(1);
    rrfptr  = alloc_q;
    freenum = free_q;
  end

`ifdef RRF_ALLOC_STATS_EN
  logic [PW-1:0] hwm_q, hwm_d;
  logic [PW-1:0] occ_d;
  logic [31:0]   scnt_q, scnt_d;

  // High-water mark tracks post-update occupancy; stall counter saturates.
  always_comb begin
    occ_d  = NUM - free_d;
    hwm_d  = (occ_d > hwm_q) ? occ_d : hwm_q;
    scnt_d = scnt_q;
    if (req1 & stall_dp & ~(&scnt_q)) begin
      scnt_d = scnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hwm_q  <= '0;
      scnt_q <= '0;
    end else begin
      hwm_q  <= hwm_d;
      scnt_q <= scnt_d;
    end
  end

  assign occ_hwm   = hwm_q;
  assign stall_cnt = scnt_q;
`else
  assign occ_hwm   = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_rrf_tag_alloc.sv
// Bench for rrf_tag_alloc: directed test-plan scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a pointer-arithmetic model.
module tb_rrf_tag_alloc;

  logic       clk = 1'b0;
  logic       reset;
  logic       req1, req2, com1en, com2en, prmiss;
  logic [6:0] rollback_ptr;
  logic       stall_dp, dpen1, dpen2;
  logic [5:0] dpaddr1, dpaddr2, com1tag, com2tag;
  logic [6:0] rrfptr, freenum, occ_hwm;
  logic [31:0] stall_cnt;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: allocation / commit positions on a 0..127 ring, stats counters
  int m_alloc = 0;
  int m_com   = 0;
  int m_hwm   = 0;
  longint m_scnt = 0;

  rrf_tag_alloc dut (
    .clk(clk), .reset(reset), .req1(req1), .req2(req2), .stall_dp(stall_dp),
    .dpaddr1(dpaddr1), .dpaddr2(dpaddr2), .dpen1(dpen1), .dpen2(dpen2),
    .rrfptr(rrfptr), .com1tag(com1tag), .com2tag(com2tag), .com1en(com1en),
    .com2en(com2en), .prmiss(prmiss), .rollback_ptr(rollback_ptr),
    .freenum(freenum), .occ_hwm(occ_hwm), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_occ();
    return (m_alloc - m_com + 128) % 128;
  endfunction

  function automatic int m_free();
    return 64 - m_occ();
  endfunction

  function automatic bit m_stall();
    int n;
    n = req1 ? (1 + int'(req2)) : 0;
    return !prmiss && (n > m_free());
  endfunction

  function automatic bit m_dpen1();
    return req1 && !m_stall() && !prmiss;
  endfunction

  function automatic int m_ncom();
    int n;
    n = com1en ? (1 + int'(com2en)) : 0;
    if (n > m_occ()) n = m_occ();
    return n;
  endfunction

  // Compare process: all outputs against the model, away from the active edge
  always @(negedge clk) begin
    if (!reset && chk_en) begin
      chk("rrfptr",   32'(rrfptr),   32'(m_alloc));
      chk("freenum",  32'(freenum),  32'(m_free()));
      chk("com1tag",  32'(com1tag),  32'(m_com % 64));
      chk("com2tag",  32'(com2tag),  32'((m_com + 1) % 64));
      chk("dpaddr1",  32'(dpaddr1),  32'(m_alloc % 64));
      chk("dpaddr2",  32'(dpaddr2),  32'((m_alloc + 1) % 64));
      chk("stall_dp", 32'(stall_dp), 32'(m_stall()));
      chk("dpen1",    32'(dpen1),    32'(m_dpen1()));
      chk("dpen2",    32'(dpen2),    32'(m_dpen1() && req2));
`ifdef RRF_ALLOC_STATS_EN
      chk("occ_hwm",   32'(occ_hwm),   32'(m_hwm));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
`else
      chk("occ_hwm",   32'(occ_hwm),   32'd0);
      chk("stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    end
  end

  // Model update on the active edge
  always @(posedge clk) begin
    int na, nc;
    bit st;
    if (reset) begin
      m_alloc = 0; m_com = 0; m_hwm = 0; m_scnt = 0;
    end else begin
      st = m_stall();
      na = m_dpen1() ? (1 + int'(req2)) : 0;
      nc = m_ncom();
      m_com = (m_com + nc) % 128;
      if (prmiss) m_alloc = int'(rollback_ptr);
      else        m_alloc = (m_alloc + na) % 128;
      if (m_occ() > m_hwm) m_hwm = m_occ();
      if (req1 && st && m_scnt < 64'hFFFF_FFFF) m_scnt++;
    end
  end

  task automatic drive(input bit r1, input bit r2, input bit c1, input bit c2,
                       input bit pm, input logic [6:0] rb);
    req1 = r1; req2 = r2; com1en = c1; com2en = c2; prmiss = pm; rollback_ptr = rb;
  endtask

  // Advance to just after the next active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 7'd0);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    int cprob;
    int nc, occ_after, rb;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 7'd0);
    tick();
    do_reset();
    chk_en = 1'b1;

    // Reset state
    #1;
    chk("rst_rrfptr",  32'(rrfptr),  32'd0);
    chk("rst_freenum", 32'(freenum), 32'd64);
    chk("rst_dpaddr1", 32'(dpaddr1), 32'd0);
    chk("rst_dpaddr2", 32'(dpaddr2), 32'd1);
    chk("rst_com1tag", 32'(com1tag), 32'd0);
    chk("rst_com2tag", 32'(com2tag), 32'd1);
    chk("rst_stall",   32'(stall_dp), 32'd0);
    chk("rst_dpen1",   32'(dpen1),   32'd0);
    chk("rst_hwm",     32'(occ_hwm), 32'd0);
    chk("rst_scnt",    32'(stall_cnt), 32'd0);

    // Fill with 32 double requests
    for (int i = 0; i < 32; i++) begin
      drive(1, 1, 0, 0, 0, 7'd0);
      #1;
      chk("fill_dpaddr1", 32'(dpaddr1), 32'(2 * i));
      chk("fill_dpaddr2", 32'(dpaddr2), 32'(2 * i + 1));
      chk("fill_dpen2",   32'(dpen2),   32'd1);
      tick();
    end
    drive(0, 0, 0, 0, 0, 7'd0);
    #1;
    chk("full_freenum", 32'(freenum), 32'd0);
    chk("full_rrfptr",  32'(rrfptr),  32'h40);
    drive(1, 0, 1, 0, 0, 7'd0);
    #1;
    chk("full_stall", 32'(stall_dp), 32'd1);
    chk("full_dpen1", 32'(dpen1),    32'd0);
    tick();
    drive(1, 0, 0, 0, 0, 7'd0);
    #1;
    chk("refill_dpaddr1", 32'(dpaddr1), 32'd0);
    chk("refill_dpen1",   32'(dpen1),   32'd1);
    chk("refill_com1tag", 32'(com1tag), 32'd1);
    tick();

    // One free tag: double request stalls, single request succeeds
    drive(0, 0, 1, 0, 0, 7'd0);
    tick();
    drive(1, 1, 0, 0, 0, 7'd0);
    #1;
    chk("one_free_freenum", 32'(freenum), 32'd1);
    chk("one_free_stall",   32'(stall_dp), 32'd1);
    chk("one_free_dpen1",   32'(dpen1),    32'd0);
    chk("one_free_dpen2",   32'(dpen2),    32'd0);
    tick();
    drive(1, 0, 0, 0, 0, 7'd0);
    #1;
    chk("single_dpen1", 32'(dpen1), 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 7'd0);
    #1;
    chk("single_freenum", 32'(freenum), 32'd0);

    // Tag wrap across 63 -> 0
    do_reset();
    drive(1, 0, 0, 0, 0, 7'd0);
    tick();
    for (int i = 0; i < 31; i++) begin
      drive(1, 1, 1, 1, 0, 7'd0);
      tick();
    end
    drive(1, 1, 0, 0, 0, 7'd0);
    #1;
    chk("wrap_rrfptr",  32'(rrfptr),  32'h3F);
    chk("wrap_dpaddr1", 32'(dpaddr1), 32'd63);
    chk("wrap_dpaddr2", 32'(dpaddr2), 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 7'd0);
    #1;
    chk("wrap_next_rrfptr", 32'(rrfptr), 32'h41);

    // Rollback with concurrent commit
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 0, 0, 7'd0);
      tick();
    end
    drive(1, 1, 1, 1, 1, 7'd4);
    #1;
    chk("rb_pre_rrfptr", 32'(rrfptr), 32'd10);
    chk("rb_dpen1", 32'(dpen1), 32'd0);
    chk("rb_dpen2", 32'(dpen2), 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 7'd0);
    #1;
    chk("rb_com1tag", 32'(com1tag), 32'd2);
    chk("rb_rrfptr",  32'(rrfptr),  32'd4);
    chk("rb_freenum", 32'(freenum), 32'd62);

    // Statistics: fill to 40, drain, fill to full, five stalled cycles
    do_reset();
    for (int i = 0; i < 20; i++) begin drive(1, 1, 0, 0, 0, 7'd0); tick(); end
    for (int i = 0; i < 20; i++) begin drive(0, 0, 1, 1, 0, 7'd0); tick(); end
    drive(0, 0, 0, 0, 0, 7'd0);
    #1;
    chk("drain_freenum", 32'(freenum), 32'd64);
`ifdef RRF_ALLOC_STATS_EN
    chk("hwm40", 32'(occ_hwm), 32'd40);
`else
    chk("hwm40", 32'(occ_hwm), 32'd0);
`endif
    for (int i = 0; i < 32; i++) begin drive(1, 1, 0, 0, 0, 7'd0); tick(); end
    for (int i = 0; i < 5; i++)  begin drive(1, 0, 0, 0, 0, 7'd0); tick(); end
    drive(0, 0, 0, 0, 0, 7'd0);
    #1;
`ifdef RRF_ALLOC_STATS_EN
    chk("hwm64",  32'(occ_hwm),   32'd64);
    chk("scnt5",  32'(stall_cnt), 32'd5);
`else
    chk("hwm64",  32'(occ_hwm),   32'd0);
    chk("scnt5",  32'(stall_cnt), 32'd0);
`endif

    // Randomized traffic with legal rollback snapshots and one mid-run reset
    do_reset();
    cprob = 60;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 250 == 0) cprob = (cprob == 60) ? 25 : 60;
      req1   = ($urandom_range(0, 99) < 70);
      req2   = ($urandom_range(0, 99) < 50);
      com1en = ($urandom_range(0, 99) < cprob);
      com2en = ($urandom_range(0, 99) < 50);
      prmiss = ($urandom_range(0, 15) == 0);
      nc = m_ncom();
      occ_after = (m_alloc - (m_com + nc) + 256) % 128;
      rb = (m_com + nc + int'($urandom_range(0, occ_after))) % 128;
      rollback_ptr = 7'(rb);
      reset = (cyc == 1500);
      tick();
    end
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 7'd0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rrf_tag_alloc.md
# rrf_tag_alloc

Rename-register allocator paired with the rename register file (RRF). At dispatch it hands out up to two consecutive RRF tags per cycle and drives the RRF dispatch-clear port (`dpaddr1/2`, `dpen1/2`). At commit it reclaims tags in program order and supplies the commit read tags (`com1tag/com2tag`). On a branch mispredict it rewinds the allocation pointer from a snapshot. Internally it is a circular buffer with head/tail pointers, each carrying a wrap bit.

## Interface
- `RRF_NUM`, 64: number of RRF entries; power of two.
- `RRF_SEL`, 6: log2(`RRF_NUM`).

Ports:
- `clk` in 1: clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req1` in 1: dispatch slot 1 needs a tag.
- `req2` in 1: dispatch slot 2 needs a tag; honoured only with `req1`.
- `stall_dp` out 1: insufficient free tags; no allocation this cycle.
- `dpaddr1`, `dpaddr2` out `RRF_SEL`: tags allocated to slots 1/2.
- `dpen1`, `dpen2` out 1: allocation performed for slots 1/2.
- `rrfptr` out `RRF_SEL+1`: allocation pointer {wrap, tag}, snapshotted by the branch unit.
- `com1tag`, `com2tag` out `RRF_SEL`: oldest and second-oldest allocated tags.
- `com1en` in 1: retire oldest tag.
- `com2en` in 1: retire second tag; honoured only with `com1en`.
- `prmiss` in 1: mispredict rollback.
- `rollback_ptr` in `RRF_SEL+1`: snapshot of `rrfptr` to restore.
- `freenum` out `RRF_SEL+1`: free-tag count, 0..`RRF_NUM`.
- `occ_hwm` out `RRF_SEL+1`: occupancy high-water mark (see Configuration).
- `stall_cnt` out 32: dispatch-stall cycle count (see Configuration).

## Operation
- State: `allocptr` {wrap, tag}, `comptr` {wrap, tag}, `freenum`.
- Invariant: `RRF_NUM - freenum == (allocptr - comptr) mod 2*RRF_NUM`.
- Tag and commit outputs:
  - `dpaddr1 = allocptr[RRF_SEL-1:0]`, `dpaddr2 = dpaddr1+1` (mod `RRF_NUM`).
  - `com1tag = comptr` tag, `com2tag = com1tag+1` (mod `RRF_NUM`).
- Request count: `nreq = req1 ? (1+req2) : 0`.
- Stall: `stall_dp = ~prmiss & (nreq > freenum)`. The free count used is from the start of the cycle; tags freed by commit this cycle are not visible until next cycle.
- Allocate: `dpen1 = req1 & ~stall_dp & ~prmiss`; `dpen2 = dpen1 & req2`. There is no partial allocation: a 2-request that sees 1 free tag stalls both slots.
- Commit: `ncom = com1en ? (1+com2en) : 0`, clipped to the current occupancy. Commits with nothing allocated are ignored. `comptr += ncom`.
- Normal update: `allocptr += dpen1+dpen2`; `freenum += ncom - (dpen1+dpen2)`.
- Rollback (`prmiss` high):
  - Dispatch is suppressed.
  - Commit still applies.
  - `allocptr <= rollback_ptr`; `freenum <= RRF_NUM - ((rollback_ptr - comptr_next) mod 2*RRF_NUM)`, where `comptr_next` is `comptr` after this cycle's commit.
- Pointer wrap: tag 63 is followed by tag 0, and the wrap bit toggles. Full is equal tags with different wrap bits; empty is equal tags with the same wrap bit.

## Timing
- Reset values:
  - `allocptr = 0`, `comptr = 0`, `freenum = RRF_NUM`.
  - `stall_dp = 0`, `dpen1 = dpen2 = 0` with no requests.
  - `dpaddr1 = 0`, `dpaddr2 = 1`, `com1tag = 0`, `com2tag = 1`.
  - `occ_hwm = 0`, `stall_cnt = 0`.
- `dpaddr*`, `dpen*`, `stall_dp` are combinational from registered state and same-cycle `req*`/`prmiss`. The RRF clears valid on the same edge.
- Allocation, commit and rollback effects are visible on `rrfptr`, `freenum` and `com*tag` the cycle after the edge. Latency is 0 to tag, 1 to pointer update.
- Reset asserted mid-operation overrides everything on that edge; no allocation or commit takes effect.

## Configuration
- `RRF_ALLOC_STATS_EN` defined:
  - `occ_hwm` holds the maximum registered occupancy since reset, updated each cycle from the post-update occupancy.
  - `stall_cnt` increments each cycle with `req1 & stall_dp` and saturates at `32'hFFFFFFFF`.
- Not defined: both outputs are tied to 0 and no stats registers are built.

## Test plan
- Reset, then `req1=req2=1` for 32 cycles: tags go 0,1 … 62,63; then `freenum=0`, `rrfptr=7'h40`; the next request gives `stall_dp=1`, `dpen1=0`.
- Full (`freenum=0`), `req1=1` with `com1en=1`: stall this cycle; next cycle `dpaddr1=0`, `dpen1=1`, `com1tag=1`.
- `freenum=1`, `req1=req2=1`: `stall_dp=1`, neither `dpen` set; with `req2=0` instead, `dpen1=1` and `freenum` goes to 0.
- `allocptr=7'h3F`, `req1=req2=1`: `dpaddr1=63`, `dpaddr2=0`; next cycle `rrfptr=7'h41`.
- 10 allocated from `comptr=0` (`rrfptr=10`), `prmiss=1`, `rollback_ptr=4`, `com1en=com2en=1`: no `dpen`; next cycle `comptr=2`, `rrfptr=4`, `freenum=62`.
- With `RRF_ALLOC_STATS_EN`: fill to 40, drain to 0, then 5 stalled-request cycles at full: `occ_hwm=64`, `stall_cnt=5`. Without the macro, both read 0.
